riscv_lsu: RTL and testbench

Load/store unit between the `riscv_core` data-memory port and a word-organised data memory with a ready handshake. It is the responder to the core's memory request: it accepts `core_req_i` and drives `core_stall_o` until the access completes. Toward memory it generates byte enables and lane-replicated write data. For loads it returns byte/half/word data, sign- or zero-extended.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/riscv_lsu_if.sv | 35 +++
 rtl/riscv_lsu.sv | 107 ++++++++++
 tb/tb_riscv_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size encodings (also used by the decoder)
// and the load/store unit state type.
package riscv_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} lsu_state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_width_t;

  // Unused encodings (3, 6, 7) fold onto word accesses.
  function automatic lsu_width_t ldst_width(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: return SZ_BYTE;
      LDST_H, LDST_HU: return SZ_HALF;
      default:         return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side request/stall port and memory-side ready-handshake port of the LSU.
interface riscv_lsu_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport lsu (
    input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    output core_rd_o, core_stall_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport core_master (
    output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
    input  core_rd_o, core_stall_o
  );

  modport mem_slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: stalls the core while a word-organised memory completes the
// access, generates byte enables / replicated store data and extends load data.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  riscv_lsu_if.lsu   bus
);

  lsu_state_t  state_q, state_d;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [31:0] rdata_q;
  logic        mem_req;
  logic [3:0]  be_raw;
  logic [NUM_LANES-1:0][VEC_W-1:0] wd_rep, rd_lanes;
  logic [1:0]  fmt_off;
  logic [2:0]  fmt_size;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;
  logic [31:0] rd_fmt;
  logic        capture;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.core_req_i) state_d = bus.mem_ready_i ? DONE : WAIT;
      WAIT:    if (bus.mem_ready_i) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the request combinationally so an abandoned access drops at once.
  always_comb begin
    mem_req = 1'b0;
    case (state_q)
      IDLE:    mem_req = bus.core_req_i;
      WAIT:    mem_req = 1'b1;
      default: mem_req = 1'b0;
    endcase
    mem_req = mem_req & rst_ni;
  end

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_req & bus.core_we_i;
  assign bus.mem_addr_o   = bus.core_addr_i;
  assign bus.mem_be_o     = mem_req ? be_raw : 4'b0000;
  assign bus.mem_wd_o     = wd_rep;
  assign bus.core_stall_o = rst_ni & bus.core_req_i & (state_q != DONE);
  assign bus.core_rd_o    = rdata_q;

  always_comb begin
    be_raw = 4'b1111;
    wd_rep = bus.core_wd_i;
    case (ldst_width(bus.core_size_i))
      SZ_BYTE: begin
        be_raw = 4'b0001 << bus.core_addr_i[1:0];
        for (int i = 0; i < NUM_LANES; i++) wd_rep[i] = bus.core_wd_i[7:0];
      end
      SZ_HALF: begin
        be_raw = 4'b0011 << {bus.core_addr_i[1], 1'b0};
        for (int i = 0; i < NUM_LANES; i++) wd_rep[i] = bus.core_wd_i[(i%2)*VEC_W +: VEC_W];
      end
      default: ;
    endcase
  end

  // A zero-wait access completes in IDLE, before the offset/size latch is loaded.
  assign fmt_off  = (state_q == IDLE) ? bus.core_addr_i[1:0] : off_q;
  assign fmt_size = (state_q == IDLE) ? bus.core_size_i      : size_q;
  assign rd_lanes = bus.mem_rd_i;
  assign rd_byte  = rd_lanes[fmt_off];
  assign rd_half  = fmt_off[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];

  always_comb begin
    rd_fmt = bus.mem_rd_i;
    case (fmt_size)
      LDST_B:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
      LDST_BU: rd_fmt = {24'h0, rd_byte};
      LDST_H:  rd_fmt = {{16{rd_half[15]}}, rd_half};
      LDST_HU: rd_fmt = {16'h0, rd_half};
      default: ;
    endcase
  end

  // A withdrawn request still finishes on the bus but its data is dropped.
  assign capture = mem_req & bus.mem_ready_i & bus.core_req_i & ~bus.core_we_i;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      off_q   <= 2'b00;
      size_q  <= 3'b000;
      rdata_q <= 32'h0;
    end else begin
      if (state_q == IDLE && bus.core_req_i) begin
        off_q  <= bus.core_addr_i[1:0];
        size_q <= bus.core_size_i;
      end
      if (capture) rdata_q <= rd_fmt;
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: transaction-level model of enables, store data
// and load extension, checked every cycle, plus hand-computed literal checks.
module tb_riscv_lsu;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  riscv_lsu_if bus();
  riscv_lsu dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic        e_stall, e_req, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_rd;
  bit          cmp_en = 1'b0;
  logic [31:0] model_rd;

  logic [3:0]  l_be0;
  logic [31:0] l_wd0, l_rd;
  logic        l_we0;
  int          l_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int lane_base(input logic [2:0] s, input logic [31:0] a);
    int b;
    b = a % 4;
    return b - (b % nbytes(s));
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int n;
    n = nbytes(s);
    return 4'(((1 << n) - 1) << lane_base(s, a));
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(s);
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = wd[(i % n)*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_ld(input logic [2:0] s, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int n;
    n = nbytes(s);
    v = rd >> (8 * lane_base(s, a));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (s < 3'd4 && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic set_idle();
    e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_wd = 32'h0; e_rd = model_rd;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", bus.core_stall_o, e_stall);
      chk("mem_req", bus.mem_req_o, e_req);
      chk("mem_we", bus.mem_we_o, e_we);
      chk("mem_be", bus.mem_be_o, e_be);
      chk("mem_addr", bus.mem_addr_o, bus.core_addr_i);
      chk("core_rd", bus.core_rd_o, e_rd);
      if (e_req) chk("mem_wd", bus.mem_wd_o, e_wd);
    end
  end

  // One access: cycle 0 in IDLE, `waits` extra cycles, then the completion cycle.
  task automatic xact(input bit we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int waits, input int drop_at);
    bit live;
    live = 1'b1;
    l_stall = 0;
    bus.core_we_i = we; bus.core_size_i = sz; bus.core_addr_i = a; bus.core_wd_i = wd;
    bus.core_req_i = 1'b1; bus.mem_rd_i = rd;
    for (int k = 0; k <= waits; k++) begin
      if (k == drop_at) begin bus.core_req_i = 1'b0; live = 1'b0; end
      bus.mem_ready_i = (k == waits);
      e_stall = live; e_req = 1'b1; e_we = we; e_be = m_be(sz, a); e_wd = m_wd(sz, wd); e_rd = model_rd;
      @(negedge clk);
      if (k == 0) begin l_be0 = bus.mem_be_o; l_wd0 = bus.mem_wd_o; l_we0 = bus.mem_we_o; end
      if (bus.core_stall_o) l_stall++;
      @(posedge clk); #1;
    end
    if (live && !we) model_rd = m_ld(sz, a, rd);
    bus.mem_ready_i = 1'b0;
    set_idle();
    @(negedge clk);
    l_rd = bus.core_rd_o;
    if (bus.core_stall_o) l_stall++;
    @(posedge clk); #1;
    bus.core_req_i = 1'b0;
    set_idle();
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.core_req_i = 1'b0; bus.core_we_i = 1'b0; bus.core_size_i = LDST_W;
    bus.core_addr_i = 32'h0; bus.core_wd_i = 32'h0; bus.mem_rd_i = 32'h0; bus.mem_ready_i = 1'b0;
    model_rd = 32'h0;
    #2;
    chk("rst_stall", bus.core_stall_o, 1'b0);
    chk("rst_req", bus.mem_req_o, 1'b0);
    chk("rst_we", bus.mem_we_o, 1'b0);
    chk("rst_be", bus.mem_be_o, 4'h0);
    chk("rst_rd", bus.core_rd_o, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    set_idle();
    cmp_en = 1'b1;
    @(posedge clk); #1;

    xact(1'b0, LDST_B, 32'h103, 32'h0, 32'h80FF_1234, 0, -1);
    chk("lb_be", l_be0, 4'b1000);
    chk("lb_rd", l_rd, 32'hFFFF_FF80);
    chk("lb_stall_cycles", l_stall, 1);
    xact(1'b0, LDST_BU, 32'h103, 32'h0, 32'h80FF_1234, 0, -1);
    chk("lbu_rd", l_rd, 32'h0000_0080);

    xact(1'b1, LDST_H, 32'h202, 32'h0000_BEEF, 32'h0, 3, -1);
    chk("sh_be", l_be0, 4'b1100);
    chk("sh_wd", l_wd0, 32'hBEEF_BEEF);
    chk("sh_we", l_we0, 1'b1);
    chk("sh_stall_cycles", l_stall, 4);

    xact(1'b0, LDST_H, 32'h002, 32'h0, 32'h8001_7FFF, 1, -1);
    chk("lh_rd", l_rd, 32'hFFFF_8001);
    xact(1'b0, LDST_HU, 32'h002, 32'h0, 32'h8001_7FFF, 0, -1);
    chk("lhu_rd", l_rd, 32'h0000_8001);

    xact(1'b0, LDST_W, 32'h010, 32'h0, 32'hCAFE_F00D, 0, -1);
    chk("lw_rd", l_rd, 32'hCAFE_F00D);
    chk("lw_stall_cycles", l_stall, 1);
    xact(1'b1, LDST_W, 32'h014, 32'h1234_5678, 32'h0, 0, -1);
    chk("sw_be", l_be0, 4'hF);
    chk("sw_wd", l_wd0, 32'h1234_5678);
    chk("sw_stall_cycles", l_stall, 1);

    xact(1'b0, LDST_H, 32'h003, 32'h0, 32'h8001_7FFF, 0, -1);
    chk("lh_misaligned_be", l_be0, 4'b1100);
    chk("lh_misaligned_rd", l_rd, 32'hFFFF_8001);
    xact(1'b0, 3'd7, 32'h001, 32'h0, 32'h1122_3344, 0, -1);
    chk("illegal_size_be", l_be0, 4'hF);
    chk("illegal_size_rd", l_rd, 32'h1122_3344);
    xact(1'b1, LDST_B, 32'h101, 32'h0000_00A5, 32'h0, 2, -1);
    chk("sb_wd", l_wd0, 32'hA5A5_A5A5);
    xact(1'b0, LDST_B, 32'h101, 32'h0, 32'h0000_7F00, 0, -1);
    chk("lb_pos_rd", l_rd, 32'h0000_007F);

    // Withdrawn load: bus completes, data dropped, next access normal.
    xact(1'b0, LDST_W, 32'h020, 32'h0, 32'hDEAD_BEEF, 3, 1);
    chk("withdraw_rd_kept", l_rd, 32'h0000_007F);
    chk("withdraw_stall_cycles", l_stall, 1);
    xact(1'b0, LDST_BU, 32'h021, 32'h0, 32'h0000_AB00, 0, -1);
    chk("after_withdraw_rd", l_rd, 32'h0000_00AB);

    // Reset while waiting on memory.
    bus.core_we_i = 1'b0; bus.core_size_i = LDST_W; bus.core_addr_i = 32'h040;
    bus.core_req_i = 1'b1; bus.mem_ready_i = 1'b0;
    e_stall = 1'b1; e_req = 1'b1; e_we = 1'b0; e_be = 4'hF; e_wd = 32'h0; e_rd = model_rd;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmp_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rstwait_stall", bus.core_stall_o, 1'b0);
    chk("rstwait_req", bus.mem_req_o, 1'b0);
    chk("rstwait_we", bus.mem_we_o, 1'b0);
    chk("rstwait_be", bus.mem_be_o, 4'h0);
    chk("rstwait_rd", bus.core_rd_o, 32'h0);
    bus.core_req_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    model_rd = 32'h0;
    set_idle();
    cmp_en = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, LDST_W, 32'h044, 32'h0, 32'h0BAD_F00D, 0, -1);
    chk("post_reset_stall_cycles", l_stall, 1);
    chk("post_reset_rd", l_rd, 32'h0BAD_F00D);

    @(posedge clk); #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got no finish want finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
